// File: rtl/conv_axil_slave_if.sv
// AXI4-Lite bus bundle for the convolution core register slave.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R).
//   slave  modport: the register block (inputs: addresses/data/valids/readies
//                   from the master; outputs: readies, responses, read data)
//   master modport: the bus master driving the block
interface conv_axil_slave_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/conv_axil_slave.sv
// AXI4-Lite register slave for the convolution core.
//   S_AXI_ACLK    clock
//   S_AXI_ARESET  synchronous active-high reset
//   s_axi         AXI4-Lite slave bus (conv_axil_slave_if.slave)
//   cfg_out       CFG3..CFG0 concatenated, CFG0 in [31:0]
//   cfg_load      one-cycle pulse when a write to CFG3 (0x0C) completes
//   res_in        result words RES3..RES0, RES0 in [31:0]
//   res_valid     capture strobe for res_in
// Map (ADDR[5:2]): 0-3 CFG0..3 RW, 4-7 RES0..3 RO (writes ignored, OKAY),
// 8-15 unmapped (writes ignored, reads return 0, both SLVERR).
module conv_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  conv_axil_slave_if.slave    s_axi,
  output logic [127:0]        cfg_out,
  output logic                cfg_load,
  input  logic [127:0]        res_in,
  input  logic                res_valid
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         NBYTES      = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [3:0][31:0] cfg_q;
  logic [3:0][31:0] res_q;
  logic [3:0][31:0] res_now;

  // ---------------- write path ----------------
  w_state_t          w_state;
  logic              awready_q, wready_q, bvalid_q;
  logic [1:0]        bresp_q;
  logic [3:0]        aw_idx_q;
  logic [31:0]       w_data_q;
  logic [NBYTES-1:0] w_strb_q;

  logic              aw_take, w_take, have_a, have_d;
  logic [3:0]        wr_idx;
  logic [31:0]       wr_data;
  logic [NBYTES-1:0] wr_strb;

  // A channel's value is either arriving this cycle or already parked in its
  // holding register; the write commits on the edge where both are present,
  // so the same-cycle AW+W case commits with latency 1.
  always_comb begin
    aw_take = s_axi.awvalid && awready_q;
    w_take  = s_axi.wvalid && wready_q;
    have_a  = aw_take || (w_state == W_HAVE_A);
    have_d  = w_take  || (w_state == W_HAVE_D);
    wr_idx  = aw_take ? s_axi.awaddr[5:2] : aw_idx_q;
    wr_data = w_take  ? s_axi.wdata       : w_data_q;
    wr_strb = w_take  ? s_axi.wstrb       : w_strb_q;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      cfg_q     <= '0;
      cfg_load  <= 1'b0;
    end else begin
      cfg_load <= 1'b0;
      if (w_state == W_RESP) begin
        if (s_axi.bready) begin
          w_state   <= W_IDLE;
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
        end
      end else begin
        if (aw_take) aw_idx_q <= s_axi.awaddr[5:2];
        if (w_take) begin
          w_data_q <= s_axi.wdata;
          w_strb_q <= s_axi.wstrb;
        end
        if (have_a && have_d) begin
          w_state   <= W_RESP;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= wr_idx[3] ? RESP_SLVERR : RESP_OKAY;
          cfg_load  <= (wr_idx == 4'd3);
          if (wr_idx[3:2] == 2'b00)
            for (int b = 0; b < NBYTES; b++)
              if (wr_strb[b]) cfg_q[wr_idx[1:0]][b*8 +: 8] <= wr_data[b*8 +: 8];
        end else if (have_a) begin
          w_state   <= W_HAVE_A;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
        end else if (have_d) begin
          w_state   <= W_HAVE_D;
          awready_q <= 1'b1;
          wready_q  <= 1'b0;
        end else begin
          // also raises the readies on the first cycle out of reset
          w_state   <= W_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
        end
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t    r_state;
  logic        arready_q, rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;
  logic [3:0]  rd_idx;
  logic [31:0] rd_val;

  // A RES read coinciding with res_valid returns the word being captured.
  always_comb begin
    res_now = res_valid ? res_in : res_q;
    rd_idx  = s_axi.araddr[5:2];
    rd_val  = '0;
    if (!rd_idx[3]) rd_val = rd_idx[2] ? res_now[rd_idx[1:0]] : cfg_q[rd_idx[1:0]];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      res_q     <= '0;
    end else begin
      if (res_valid) res_q <= res_in;
      if (r_state == R_IDLE) begin
        arready_q <= 1'b1;
        if (s_axi.arvalid && arready_q) begin
          r_state   <= R_DATA;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_val;
          rresp_q   <= rd_idx[3] ? RESP_SLVERR : RESP_OKAY;
        end
      end else if (s_axi.rready) begin
        r_state   <= R_IDLE;
        arready_q <= 1'b1;
        rvalid_q  <= 1'b0;
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign cfg_out       = cfg_q;

  // protection bits and byte-offset address bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
endmodule
